// File: rtl/vga_text_console_writer.sv
// ---------------------------------------------------------------------------
// vga_text_console_writer
//
// Terminal-style producer for the text-mode character buffer write port.
// Takes a byte stream over valid/ready, keeps a cursor, turns printable bytes
// into single buffer writes, and interprets a few control codes:
//   0x0D CR  : column to 0, no write
//   0x0A LF  : column to 0, next row (wraps to top), no write
//   0x09 TAB : column up to the next multiple of 8, LF if past the last column
//   0x08 BS  : step back one cell (across row start) and blank it
//   0x0C FF  : sweep CLEAR_CHAR over the whole buffer, then home the cursor
//
// Optional build macro:
//   VGA_CONSOLE_CLEAR_ON_RESET_EN - reset enters the clear sweep instead of
//   IDLE, so the buffer is blanked after every reset before ready_o rises.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   data_i      input byte
//   valid_i     data_i valid
//   ready_o     byte accepted on this edge when valid_i is also high
//   char_o      character written to the buffer (registered)
//   addr_o      buffer address y*COLS+x (registered)
//   wen_o       one-cycle write strobe (registered)
//   cursor_x_o  cursor column
//   cursor_y_o  cursor row
//   busy_o      clear sweep in progress
// ---------------------------------------------------------------------------
module vga_text_console_writer #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20,
    localparam int         AW         = $clog2(COLS*ROWS),
    localparam int         XW         = $clog2(COLS),
    localparam int         YW         = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [7:0]    char_o,
    output logic [AW-1:0] addr_o,
    output logic          wen_o,
    output logic [XW-1:0] cursor_x_o,
    output logic [YW-1:0] cursor_y_o,
    output logic          busy_o
);

    localparam logic [7:0] CODE_BS  = 8'h08;
    localparam logic [7:0] CODE_TAB = 8'h09;
    localparam logic [7:0] CODE_LF  = 8'h0A;
    localparam logic [7:0] CODE_FF  = 8'h0C;
    localparam logic [7:0] CODE_CR  = 8'h0D;

    localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(ROWS - 1);
    localparam logic [AW-1:0] CNT_LAST = AW'(COLS*ROWS - 1);
    localparam logic [AW-1:0] COLS_A   = AW'(COLS);
    localparam logic [XW:0]   COLS_X   = (XW+1)'(COLS);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t          state;
    logic [AW-1:0]   clear_cnt;
    logic [XW-1:0]   cursor_x;
    logic [YW-1:0]   cursor_y;

    // Derived cursor values used by the byte decoder.
    logic [YW-1:0]   y_down;      // next row with wrap to top
    logic [YW-1:0]   y_up;        // previous row (only used when y > 0)
    logic [XW-1:0]   x_left;      // previous column (only used when x > 0)
    logic [XW:0]     tab_sum;     // next multiple of 8, one bit wider to see overflow
    logic            tab_wrap;
    logic [AW-1:0]   addr_here;
    logic [AW-1:0]   addr_bs;

    function automatic logic [AW-1:0] lin_addr(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
        return AW'(y) * COLS_A + AW'(x);
    endfunction

    assign ready_o    = (state == IDLE);
    assign busy_o     = (state == CLEAR);
    assign cursor_x_o = cursor_x;
    assign cursor_y_o = cursor_y;

    // NOTE: every signal assigned in always_comb gets a value on every path;
    // a missing default would infer a latch.
    always_comb begin
        y_down    = (cursor_y == Y_LAST) ? '0 : cursor_y + 1'b1;
        y_up      = cursor_y - 1'b1;
        x_left    = cursor_x - 1'b1;
        // Clear the low three bits and add 8: strictly the next tab stop.
        tab_sum   = {1'b0, cursor_x[XW-1:3], 3'b000} + (XW+1)'(8);
        tab_wrap  = (tab_sum >= COLS_X);
        addr_here = lin_addr(cursor_x, cursor_y);
        addr_bs   = (cursor_x != '0) ? lin_addr(x_left, cursor_y)
                                     : lin_addr(X_LAST, y_up);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_STATE;
            clear_cnt <= '0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            char_o    <= '0;
            addr_o    <= '0;
            wen_o     <= 1'b0;
        end else begin
            // Strobe is low unless a write is scheduled below.
            wen_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (valid_i) begin
                        case (data_i)
                            CODE_CR: begin
                                cursor_x <= '0;
                            end

                            CODE_LF: begin
                                cursor_x <= '0;
                                cursor_y <= y_down;
                            end

                            CODE_TAB: begin
                                if (tab_wrap) begin
                                    cursor_x <= '0;
                                    cursor_y <= y_down;
                                end else begin
                                    cursor_x <= tab_sum[XW-1:0];
                                end
                            end

                            CODE_BS: begin
                                // At home position there is nothing to erase.
                                if (cursor_x != '0) begin
                                    cursor_x <= x_left;
                                    wen_o    <= 1'b1;
                                    addr_o   <= addr_bs;
                                    char_o   <= CLEAR_CHAR;
                                end else if (cursor_y != '0) begin
                                    cursor_x <= X_LAST;
                                    cursor_y <= y_up;
                                    wen_o    <= 1'b1;
                                    addr_o   <= addr_bs;
                                    char_o   <= CLEAR_CHAR;
                                end
                            end

                            CODE_FF: begin
                                state     <= CLEAR;
                                clear_cnt <= '0;
                            end

                            default: begin
                                wen_o  <= 1'b1;
                                addr_o <= addr_here;
                                char_o <= data_i;
                                if (cursor_x == X_LAST) begin
                                    cursor_x <= '0;
                                    cursor_y <= y_down;
                                end else begin
                                    cursor_x <= cursor_x + 1'b1;
                                end
                            end
                        endcase
                    end
                end

                CLEAR: begin
                    wen_o  <= 1'b1;
                    addr_o <= clear_cnt;
                    char_o <= CLEAR_CHAR;
                    if (clear_cnt == CNT_LAST) begin
                        // Last cell issued this cycle; a byte can be taken on
                        // the very next edge, so its write follows back-to-back.
                        state     <= IDLE;
                        clear_cnt <= '0;
                        cursor_x  <= '0;
                        cursor_y  <= '0;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_console_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_console_writer
//
// Directed bench for vga_text_console_writer at default geometry (80x30) with
// the clear-on-reset macro undefined. Inputs change on the falling edge or
// 1 ns after the rising edge; outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_vga_text_console_writer;

    localparam int AW = 12;
    localparam int XW = 7;
    localparam int YW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data_i = 8'h00;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [7:0]    char_o;
    logic [AW-1:0] addr_o;
    logic          wen_o;
    logic [XW-1:0] cursor_x_o;
    logic [YW-1:0] cursor_y_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    vga_text_console_writer dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .char_o     (char_o),
        .addr_o     (addr_o),
        .wen_o      (wen_o),
        .cursor_x_o (cursor_x_o),
        .cursor_y_o (cursor_y_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        check({tag, ".x"}, 32'(cursor_x_o), 32'(x));
        check({tag, ".y"}, 32'(cursor_y_o), 32'(y));
    endtask

    task automatic check_write(input string tag, input logic en, input int addr, input logic [7:0] ch);
        check({tag, ".wen"}, 32'(wen_o), 32'(en));
        if (en) begin
            check({tag, ".addr"}, 32'(addr_o), 32'(addr));
            check({tag, ".char"}, 32'(char_o), 32'(ch));
        end
    endtask

    // One byte accepted on the next rising edge; returns 1 ns after that edge,
    // where the resulting write (if any) is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data_i  = b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int low_cnt;
        int wr_cnt;
        int bad_cnt;
        bit got_q;

        // 1. Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.ready", 32'(ready_o), 32'd1);
        check("rst.busy",  32'(busy_o),  32'd0);
        check("rst.wen",   32'(wen_o),   32'd0);
        check("rst.addr",  32'(addr_o),  32'd0);
        check("rst.char",  32'(char_o),  32'd0);
        check_cursor("rst.cur", 0, 0);

        // 2. Back-to-back printable bytes.
        @(negedge clk);
        data_i  = 8'h41;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        check_write("b2b.A", 1'b1, 0, 8'h41);
        check_cursor("b2b.A.cur", 1, 0);
        data_i = 8'h42;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check_write("b2b.B", 1'b1, 1, 8'h42);
        check_cursor("b2b.B.cur", 2, 0);
        @(posedge clk);
        #1;
        check_write("b2b.idle", 1'b0, 0, 8'h00);

        // 3. End-of-row and end-of-screen wrap.
        send(8'h0D);
        check_write("cr", 1'b0, 0, 8'h00);
        check_cursor("cr.cur", 0, 0);
        repeat (79) send(8'h2E);
        check_cursor("row0.end", 79, 0);
        send(8'h5A);
        check_write("wrap.row", 1'b1, 79, 8'h5A);
        check_cursor("wrap.row.cur", 0, 1);
        repeat (28) send(8'h0A);
        check_cursor("lf28", 0, 29);
        repeat (79) send(8'h2E);
        send(8'h5A);
        check_write("wrap.scr", 1'b1, 2399, 8'h5A);
        check_cursor("wrap.scr.cur", 0, 0);

        // 4. LF, BS across row start, TAB overflow, TAB, BS mid-row, LF wrap, BS at home.
        repeat (3) send(8'h0A);
        repeat (5) send(8'h2E);
        check_cursor("pos53", 5, 3);
        send(8'h0A);
        check_write("lf", 1'b0, 0, 8'h00);
        check_cursor("lf.cur", 0, 4);
        send(8'h08);
        check_write("bs.row", 1'b1, 319, 8'h20);
        check_cursor("bs.row.cur", 79, 3);
        send(8'h09);
        check_write("tab.ovf", 1'b0, 0, 8'h00);
        check_cursor("tab.ovf.cur", 0, 4);
        send(8'h09);
        check_write("tab", 1'b0, 0, 8'h00);
        check_cursor("tab.cur", 8, 4);
        send(8'h08);
        check_write("bs.mid", 1'b1, 327, 8'h20);
        check_cursor("bs.mid.cur", 7, 4);
        repeat (26) send(8'h0A);
        check_cursor("lf.wrap", 0, 0);
        send(8'h08);
        check_write("bs.home", 1'b0, 0, 8'h00);
        check_cursor("bs.home.cur", 0, 0);

        // 5. Form feed with valid held high and 'Q' queued behind it.
        @(negedge clk);
        data_i  = 8'h0C;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        data_i  = 8'h51;
        low_cnt = 0;
        wr_cnt  = 0;
        bad_cnt = 0;
        got_q   = 1'b0;
        for (int c = 0; c < 2600 && !got_q; c++) begin
            if (!ready_o) low_cnt++;
            if (wen_o) begin
                if (char_o == 8'h51) begin
                    got_q = 1'b1;
                end else begin
                    if (addr_o != AW'(wr_cnt) || char_o != 8'h20) bad_cnt++;
                    wr_cnt++;
                end
            end
            if (!got_q) begin
                @(posedge clk);
                #1;
            end
        end
        valid_i = 1'b0;
        check("ff.ready_low", 32'(low_cnt), 32'd2400);
        check("ff.writes",    32'(wr_cnt),  32'd2400);
        check("ff.bad",       32'(bad_cnt), 32'd0);
        check("ff.got_q",     32'(got_q),   32'd1);
        check_write("ff.q", 1'b1, 0, 8'h51);
        check_cursor("ff.q.cur", 1, 0);

        // 6. Reset in the middle of a sweep.
        send(8'h0C);
        check("mid.busy0", 32'(busy_o), 32'd1);
        repeat (1000) @(posedge clk);
        #1;
        check_write("mid.sweep", 1'b1, 999, 8'h20);
        rst = 1'b1;
        #1;
        check("mid.rst.wen",   32'(wen_o),   32'd0);
        check("mid.rst.busy",  32'(busy_o),  32'd0);
        check("mid.rst.ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid.rel.ready", 32'(ready_o), 32'd1);
        check_cursor("mid.rel.cur", 0, 0);
        send(8'h41);
        check_write("mid.after", 1'b1, 0, 8'h41);
        check_cursor("mid.after.cur", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
